// File: rtl/serial_comp_nbit_ncc.sv
// Bit-serial N-bit magnitude comparator, LSB first: o = (G >= E), eq = (G == E).
// Define SIGNED_CMP_EN to treat operands as two's complement (sign bit uses the swapped rule).
module serial_comp_nbit_ncc #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic g_input,
  input  logic e_input,
  output logic o,
  output logic eq,
  output logic done
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic          diff;
  logic          o_next;

  always_comb begin
    diff   = g_input ^ e_input;
    // A differing bit decides the result, since every later bit is more significant.
    o_next = (g_input & ~e_input) | (~diff & o);
`ifdef SIGNED_CMP_EN
    if (cnt == LAST) begin
      o_next = (e_input & ~g_input) | (~diff & o);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o    <= 1'b1;
      eq   <= 1'b1;
      done <= 1'b0;
      cnt  <= '0;
    end else if (!done) begin
      o    <= o_next;
      eq   <= eq & ~diff;
      cnt  <= cnt + 1'b1;
      done <= (cnt == LAST);
    end
  end

endmodule

// File: tb/tb_serial_comp_nbit_ncc.sv
// Scoreboard bench for serial_comp_nbit_ncc: directed plan vectors plus random operands.
module tb_serial_comp_nbit_ncc;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic g_input = 1'b0;
  logic e_input = 1'b0;
  logic o, eq, done;

  typedef struct packed {
    logic o;
    logic eq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bits_issued = 0;
  logic done_q = 1'b0;

  serial_comp_nbit_ncc #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .g_input(g_input),
    .e_input(e_input),
    .o      (o),
    .eq     (eq),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic ref_ge(input logic [N-1:0] gv, input logic [N-1:0] ev);
`ifdef SIGNED_CMP_EN
    return $signed(gv) >= $signed(ev);
`else
    return gv >= ev;
`endif
  endfunction

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    g_input = 1'($urandom);
    e_input = 1'($urandom);
    @(posedge clk);
    bits_issued = 0;
    #1;
    check("reset_o", o, 1'b1);
    check("reset_eq", eq, 1'b1);
    check("reset_done", done, 1'b0);
  endtask

  task automatic consume(input logic g, input logic e);
    @(negedge clk);
    rst     = 1'b0;
    g_input = g;
    e_input = e;
    @(posedge clk);
    bits_issued++;
  endtask

  task automatic run_cmp(input logic [N-1:0] gv, input logic [N-1:0] ev, input bit hold);
    exp_t x;
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      consume(gv[i], ev[i]);
      if (i < int'(N) - 1) begin
        #1 check("done_early", done, 1'b0);
      end
    end
    x.o  = ref_ge(gv, ev);
    x.eq = (gv == ev);
    sb.push_back(x);
    @(negedge clk);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        g_input = 1'b0;
        e_input = 1'b1;
        @(posedge clk);
        #1;
        check("hold_o", o, x.o);
        check("hold_eq", eq, x.eq);
        check("hold_done", done, 1'b1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done rose with no pending result, bits=%0d", bits_issued);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (bits_issued != int'(N) || o !== x.o || eq !== x.eq) begin
          errors++;
          $display("FAIL result: o=%b eq=%b bits=%0d expected o=%b eq=%b bits=%0d",
                   o, eq, bits_issued, x.o, x.eq, N);
        end
      end
    end
    done_q = done;
  end

  initial begin
`ifdef SIGNED_CMP_EN
    run_cmp(8'hA9, 8'h7B, 1'b0);
    run_cmp(8'hFF, 8'hFE, 1'b0);
`endif
    run_cmp(8'hA9, 8'h7B, 1'b1);
    run_cmp(8'h74, 8'hFD, 1'b0);
    run_cmp(8'hAA, 8'hAA, 1'b1);

    // Abort after 4 bits, then a full comparison.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      consume(1'b0, 1'b1);
      #1 check("abort_done", done, 1'b0);
    end
    run_cmp(8'hFF, 8'h00, 1'b0);

    // Reset arriving on the edge that would complete the comparison.
    do_reset();
    for (int i = 0; i < int'(N) - 1; i++) consume(1'($urandom), 1'($urandom));
    do_reset();
    check("rst_wins_done", done, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] gv, ev;
      gv = N'($urandom);
      ev = (t % 5 == 0) ? gv : N'($urandom);
      run_cmp(gv, ev, (t % 8 == 0));
    end

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results never presented, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
